// File: rtl/tart_dram_arbiter.sv
// ============================================================================
// Module   : tart_dram_arbiter
// Function : Shares one DRAM port between the acquisition writer and the SPI
//            prefetcher, keeping the DRAM as a circular sample buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tart_dram_arbiter #(
    parameter int DBITS = 24,
    parameter int ABITS = 25,
    parameter int HIWAT = 2 ** (ABITS - 1),
    parameter int DELAY = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             clr_i,
    input  logic             wr_req_i,
    input  logic [DBITS-1:0] wr_dat_i,
    output logic             wr_ack_o,
    input  logic             rd_req_i,
    output logic             rd_ack_o,
    output logic [DBITS-1:0] rd_dat_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [ABITS-1:0] mem_adr_o,
    output logic [DBITS-1:0] mem_dat_o,
    input  logic             mem_ack_i,
    input  logic [DBITS-1:0] mem_dat_i,
    output logic [ABITS-1:0] wr_adr_o,
    output logic [ABITS-1:0] rd_adr_o,
    output logic [ABITS:0]   level_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overflow_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ABITS:0] c_FULL  = {1'b1, {ABITS{1'b0}}};
    localparam logic [ABITS:0] c_HIWAT = (ABITS + 1)'(HIWAT);
    localparam logic [ABITS:0] c_ONE   = (ABITS + 1)'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ABITS:0]     r_wp;
    logic [ABITS:0]     r_rp;
    logic               r_ovf;
    logic               r_clr_pend;
    logic               r_last_wr;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ABITS-1:0]   r_mem_adr;
    logic [DBITS-1:0]   r_mem_dat;
    logic [DBITS-1:0]   r_rd_dat;
    logic               r_wr_ack;
    logic               r_rd_ack;

    logic [ABITS:0]     w_level;
    logic               w_empty;
    logic               w_full;
    logic               w_wr_req;
    logic               w_clr;
    logic               w_wr_win;
    logic               w_grant_wr;
    logic               w_grant_rd;
    logic               w_drop;
    logic               w_unused_delay;

    // DELAY only shaped simulation timing in older flows; nothing here uses it.
    assign w_unused_delay = (DELAY != 0);

    assign w_level  = r_wp - r_rp;
    assign w_empty  = (w_level == '0);
    assign w_full   = (w_level == c_FULL);
    // A write request still high during its own drop-ack is the old request.
    assign w_wr_req = wr_req_i && !r_wr_ack;
    assign w_clr    = clr_i || r_clr_pend;
    assign w_wr_win = w_wr_req &&
                      ((w_level >= c_HIWAT) || !rd_req_i || w_empty || !r_last_wr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_wr  = 1'b0;
        w_grant_rd  = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_clr || !enable_i) begin
                    w_state_nxt = S_IDLE;
                end else if (w_wr_req && w_full) begin
                    w_drop = 1'b1;
                end else if (w_wr_win) begin
                    w_grant_wr  = 1'b1;
                    w_state_nxt = S_WRITE;
                end else if (rd_req_i && !w_empty) begin
                    w_grant_rd  = 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            S_WRITE, S_READ: begin
                if (mem_ack_i) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_ovf      <= 1'b0;
            r_clr_pend <= 1'b0;
            r_last_wr  <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_adr  <= '0;
            r_mem_dat  <= '0;
            r_rd_dat   <= '0;
            r_wr_ack   <= 1'b0;
            r_rd_ack   <= 1'b0;
        end else begin
            r_wr_ack <= 1'b0;
            r_rd_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_clr) begin
                        r_wp       <= '0;
                        r_rp       <= '0;
                        r_ovf      <= 1'b0;
                        r_clr_pend <= 1'b0;
                    end
                    if (w_drop) begin
                        r_wr_ack <= 1'b1;
                        r_ovf    <= 1'b1;
                    end
                    if (w_grant_wr || w_grant_rd) begin
                        r_mem_req <= 1'b1;
                        r_mem_we  <= w_grant_wr;
                        r_mem_adr <= w_grant_wr ? r_wp[ABITS-1:0] : r_rp[ABITS-1:0];
                    end
                    if (w_grant_wr) begin
                        r_mem_dat <= wr_dat_i;
                    end
                end
                S_WRITE, S_READ: begin
                    if (clr_i) begin
                        r_clr_pend <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        r_mem_req <= 1'b0;
                        if (r_state == S_WRITE) begin
                            r_wr_ack <= 1'b1;
                        end else begin
                            r_rd_ack <= 1'b1;
                            r_rd_dat <= mem_dat_i;
                        end
                    end
                end
                S_DONE: begin
                    r_last_wr <= r_mem_we;
                    // A pending or simultaneous clear swallows this increment.
                    if (w_clr) begin
                        r_wp       <= '0;
                        r_rp       <= '0;
                        r_ovf      <= 1'b0;
                        r_clr_pend <= 1'b0;
                    end else if (r_mem_we) begin
                        r_wp <= r_wp + c_ONE;
                    end else begin
                        r_rp <= r_rp + c_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_ack_o   = r_wr_ack;
    assign rd_ack_o   = r_rd_ack;
    assign rd_dat_o   = r_rd_dat;
    assign mem_req_o  = r_mem_req;
    assign mem_we_o   = r_mem_we;
    assign mem_adr_o  = r_mem_adr;
    assign mem_dat_o  = r_mem_dat;
    assign wr_adr_o   = r_wp[ABITS-1:0];
    assign rd_adr_o   = r_rp[ABITS-1:0];
    assign level_o    = w_level;
    assign empty_o    = w_empty;
    assign full_o     = w_full;
    assign overflow_o = r_ovf;

endmodule

`default_nettype wire

// File: doc/tart_dram_arbiter.md
Name: tart_dram_arbiter

Overview:
Shares the single DRAM port between two requesters: the acquisition writer, which streams raw antenna samples in, and the SPI-side prefetcher, which streams them back out. The block manages the DRAM as a circular sample buffer with write and read pointers, a fill level and a sticky overflow flag. Its address and status outputs feed the acquisition status registers.

Parameters:
DBITS, 24, sample word width (one bit per antenna)
ABITS, 25, DRAM word-address width; buffer depth is 2^ABITS words
HIWAT, 2^(ABITS-1), fill level at which writes override round-robin
DELAY, 3, simulation-only register delay

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
enable_i  in  1  permits new grants
clr_i  in  1  pulse: clear pointers and overflow
wr_req_i  in  1  acquisition write request, held until wr_ack_o
wr_dat_i  in  DBITS  sample to store
wr_ack_o  out  1  one-cycle write completion or drop
rd_req_i  in  1  prefetch read request, held until rd_ack_o
rd_ack_o  out  1  one-cycle read completion, rd_dat_o valid
rd_dat_o  out  DBITS  read sample
mem_req_o  out  1  DRAM request, held until mem_ack_i
mem_we_o  out  1  1 = write
mem_adr_o  out  ABITS  DRAM word address
mem_dat_o  out  DBITS  DRAM write data
mem_ack_i  in  1  DRAM completion; mem_dat_i valid this cycle on reads
mem_dat_i  in  DBITS  DRAM read data
wr_adr_o  out  ABITS  write pointer
rd_adr_o  out  ABITS  read pointer
level_o  out  ABITS+1  stored-sample count
empty_o  out  1  level_o == 0
full_o  out  1  level_o == 2^ABITS
overflow_o  out  1  sticky: a write was dropped

Behaviour:
- Reset: all outputs 0 except empty_o=1; FSM is IDLE; last-grant = READ.
- Pointers are ABITS+1 bits wide, including a wrap bit. level = wp - rp (mod 2^(ABITS+1)). wr_adr_o and rd_adr_o are the low ABITS bits. Pointers wrap silently.
- FSM states are IDLE, WRITE, READ, DONE.
- IDLE, evaluated in priority order:
  - clr_i pending: pointers := 0, overflow := 0, stay in IDLE.
  - enable_i=0: stay in IDLE.
  - wr_req_i && full: drop. Pulse wr_ack_o next cycle, set overflow_o, no DRAM access, stay in IDLE.
  - wr_req_i && (level >= HIWAT || !rd_req_i || empty || last-grant==READ): go to WRITE.
  - rd_req_i && !empty: go to READ.
- WRITE and READ:
  - mem_req_o=1 from the cycle after the grant decision.
  - mem_we_o, mem_adr_o and mem_dat_o are registered at grant and stable until mem_ack_i.
  - On mem_ack_i, go to DONE and drop mem_req_o that same edge.
  - A READ captures mem_dat_i into rd_dat_o.
- DONE (one cycle):
  - Pulse the matching wr_ack_o or rd_ack_o.
  - Increment the matching pointer.
  - Update last-grant.
  - Return to IDLE.
  - Requesters see the ack and must drop or re-present the request by the following edge.
- Minimum transaction is 4 cycles: grant, req, ack, DONE.
- Back-to-back requests from both sides alternate (round-robin) until level >= HIWAT. From then on writes always win.
- clr_i arriving outside IDLE is latched and applied at the next IDLE. The in-flight transaction completes and its pointer increment is then discarded by the clear.
- enable_i falling mid-transaction lets the transaction complete.
- rst_i mid-transaction drops mem_req_o on the next edge; the DRAM controller tolerates abandonment.
- Simultaneous clr_i with a DONE: the clear takes precedence over the increment.
- rd_dat_o holds its value until the next read completes.

Test Plan:
- Write-only: reset, enable, 4 writes of 0x000001..0x000004 with mem_ack_i 2 cycles after mem_req_o -> mem_adr_o 0..3, mem_we_o=1, level_o=4, wr_adr_o=4, each wr_ack_o 4 cycles after grant.
- Readback: then 4 reads -> rd_dat_o 0x000001..0x000004 in order, empty_o=1, rd_adr_o=4.
- Contention: both requests held with level < HIWAT -> grants alternate W,R,W,R. Force level >= HIWAT -> four consecutive writes.
- Full/overflow: ABITS=3, 8 writes -> full_o=1. 9th write -> wr_ack_o pulses with no mem_req_o, overflow_o=1, level_o stays 8. clr_i -> level_o=0, overflow_o=0.
- Wrap: ABITS=3, write 6, read 6, write 4 -> mem_adr_o 6,7,0,1, level_o=4.
- Reset mid-read: rst_i while mem_req_o=1 -> mem_req_o=0 next cycle, no rd_ack_o, all pointers 0.
